// File: rtl/key_loader.sv
// key_loader
// Serial key-delivery block for a locked combinational netlist.
// A key arrives serially, LSB first, followed by one even-parity bit, and is
// assembled in a shift register. If the parity check passes, the key is
// committed to a held output register that drives the core's keyIn_0_* pins.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse; begins a new load and aborts any load in progress
//   bit_in     serial key data (LSB first), then the parity bit
//   bit_valid  bit_in is accepted on cycles where this is high while loading
//   clear      zeroes key_out, drops key_ready, aborts any load
//   key_out    committed key; key_out[i] drives keyIn_0_i
//   key_ready  high while key_out holds a parity-checked key
//   busy       high while a load is in progress (SHIFT or PARITY)
//   error      sticky parity-failure flag
module key_loader #(
  parameter int KEY_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_ready,
  output logic                 busy,
  output logic                 error
);

  localparam int CntW = $clog2(KEY_WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(KEY_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t                state_q;
  logic [KEY_WIDTH-1:0]  shreg_q;
  logic [KEY_WIDTH-1:0]  shreg_d;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [CntW-1:0]       cnt_q;
  logic                  par_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  error_q;

  // Shift-register insert: the incoming bit lands at position cnt_q. A
  // compare-per-bit mask keeps the index width independent of the counter.
  always_comb begin
    shreg_d = shreg_q;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (cnt_q == CntW'(i)) begin
        shreg_d[i] = bit_in;
      end
    end
  end

  // Load FSM with all outputs registered. Priority is rst, clear, start,
  // then bit_valid, so a start in the same cycle as a bit drops the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (start) begin
      // key_q/ready_q are left alone: the previous good key keeps driving
      // the core until a new one commits.
      state_q <= SHIFT;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b1;
      error_q <= 1'b0;
    end else if (bit_valid) begin
      case (state_q)
        SHIFT: begin
          shreg_q <= shreg_d;
          par_q   <= par_q ^ bit_in;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastIdx) begin
            state_q <= PARITY;
          end
        end
        PARITY: begin
          // Even parity: data XOR plus parity bit must be zero.
          if ((par_q ^ bit_in) == 1'b0) begin
            key_q   <= shreg_q;
            ready_q <= 1'b1;
          end else begin
            error_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign key_out   = key_q;
  assign key_ready = ready_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader
// Directed testbench for key_loader. Two instances share the clock and reset:
// a 16-bit one for the main scenarios and a 2-bit one for the minimum width.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// there too, so every check sees the state after the previous edge.
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] key_out;
  logic        key_ready;
  logic        busy;
  logic        error;

  logic        start2 = 1'b0;
  logic        bit2 = 1'b0;
  logic        bv2 = 1'b0;
  logic        clear2 = 1'b0;
  logic [1:0]  key2;
  logic        ready2;
  logic        busy2;
  logic        error2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_loader #(.KEY_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
    .bit_valid(bit_valid), .clear(clear), .key_out(key_out),
    .key_ready(key_ready), .busy(busy), .error(error)
  );

  key_loader #(.KEY_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bit_in(bit2),
    .bit_valid(bv2), .clear(clear2), .key_out(key2),
    .key_ready(ready2), .busy(busy2), .error(error2)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a full 16-bit load: start cycle (optionally with a bit that must
  // be dropped), 16 data bits LSB first, then the parity bit, no gaps.
  task automatic applyStimulus(input logic [15:0] k, input logic p, input logic bvAtStart);
    start = 1'b1; bit_valid = bvAtStart; bit_in = bvAtStart;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1; bit_in = k[i];
      tick();
    end
    bit_in = p;
    tick();
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (key_out !== 16'h0000) begin failures++; $display("[TB] FAIL reset_key_out: got %h expected 0000", key_out); end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_key_ready: got %b expected 0", key_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error: got %b expected 0", error); end
    checks++; if (ready2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_w2: got ready=%b busy=%b expected 0 0", ready2, busy2); end
  endtask

  task automatic test_basic_load();
    logic [15:0] k;
    k = 16'hA5C3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      bit_valid = 1'b1;
      bit_in = (c <= 16) ? k[c-1] : 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_c%0d: got %b expected 1", c, busy); end
      checks++; if (key_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_ready_c%0d: got %b expected 0", c, key_ready); end
      tick();
    end
    bit_valid = 1'b0;
    checks++; if (key_out !== 16'hA5C3) begin failures++; $display("[TB] FAIL basic_key_out: got %h expected a5c3", key_out); end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_key_ready: got %b expected 1", key_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL basic_error: got %b expected 0", error); end
  endtask

  task automatic test_parity_error();
    applyStimulus(16'h0001, 1'b0, 1'b0);
    checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL perr_error: got %b expected 1", error); end
    checks++; if (key_out !== 16'hA5C3) begin failures++; $display("[TB] FAIL perr_key_out: got %h expected a5c3", key_out); end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("[TB] FAIL perr_key_ready: got %b expected 1", key_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL perr_busy: got %b expected 0", busy); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL perr_start_clears: got %b expected 0", error); end
    checks++; if (key_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL perr_restart: got ready=%b busy=%b expected 1 1", key_ready, busy); end
  endtask

  task automatic test_gaps();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if ((i % 2) == 0 && (i / 2) < 17) begin
        bit_valid = 1'b1; bit_in = ((i / 2) < 16) ? 1'b1 : 1'b0;
      end else begin
        bit_valid = 1'b0; bit_in = 1'b0;
      end
      if (i == 20 || i == 32) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL gaps_busy_i%0d: got %b expected 1", i, busy); end
        checks++; if (key_out !== 16'hA5C3) begin failures++; $display("[TB] FAIL gaps_hold_i%0d: got %h expected a5c3", i, key_out); end
      end
      tick();
    end
    checks++; if (key_out !== 16'hFFFF) begin failures++; $display("[TB] FAIL gaps_key_out: got %h expected ffff", key_out); end
    checks++; if (key_ready !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin failures++; $display("[TB] FAIL gaps_flags: got ready=%b busy=%b err=%b expected 1 0 0", key_ready, busy, error); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    applyStimulus(16'h1234, 1'b1, 1'b1);
    checks++; if (key_out !== 16'h1234) begin failures++; $display("[TB] FAIL abort_key_out: got %h expected 1234", key_out); end
    checks++; if (error !== 1'b0 || key_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_flags: got err=%b ready=%b expected 0 1", error, key_ready); end
  endtask

  task automatic test_reset_midload();
    applyStimulus(16'hBEEF, 1'b1, 1'b0);
    checks++; if (key_out !== 16'hBEEF) begin failures++; $display("[TB] FAIL rstmid_commit: got %h expected beef", key_out); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (key_out !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_key_out: got %h expected 0000", key_out); end
    checks++; if (key_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_flags: got ready=%b busy=%b err=%b expected 0 0 0", key_ready, busy, error); end
    for (int i = 0; i < 20; i++) tick();
    bit_valid = 1'b0;
    checks++; if (busy !== 1'b0 || key_ready !== 1'b0 || key_out !== 16'h0000) begin failures++; $display("[TB] FAIL rstmid_idle: got busy=%b ready=%b key=%h expected 0 0 0000", busy, key_ready, key_out); end
  endtask

  task automatic test_clear();
    applyStimulus(16'hBEEF, 1'b1, 1'b0);
    applyStimulus(16'h0001, 1'b0, 1'b0);
    checks++; if (error !== 1'b1 || key_out !== 16'hBEEF) begin failures++; $display("[TB] FAIL clear_pre: got err=%b key=%h expected 1 beef", error, key_out); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (key_out !== 16'h0000 || key_ready !== 1'b0) begin failures++; $display("[TB] FAIL clear_idle_key: got key=%h ready=%b expected 0000 0", key_out, key_ready); end
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL clear_idle_flags: got err=%b busy=%b expected 0 0", error, busy); end
    applyStimulus(16'hBEEF, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (key_out !== 16'h0000 || key_ready !== 1'b0) begin failures++; $display("[TB] FAIL clear_mid_key: got key=%h ready=%b expected 0000 0", key_out, key_ready); end
    checks++; if (busy !== 1'b0 || error !== 1'b0) begin failures++; $display("[TB] FAIL clear_mid_flags: got busy=%b err=%b expected 0 0", busy, error); end
    for (int i = 0; i < 10; i++) tick();
    bit_valid = 1'b0;
    checks++; if (busy !== 1'b0 || key_ready !== 1'b0) begin failures++; $display("[TB] FAIL clear_after: got busy=%b ready=%b expected 0 0", busy, key_ready); end
  endtask

  task automatic test_width2();
    bv2 = 1'b1; bit2 = 1'b1;
    tick(); tick(); tick();
    bv2 = 1'b0;
    checks++; if (busy2 !== 1'b0 || ready2 !== 1'b0 || key2 !== 2'b00) begin failures++; $display("[TB] FAIL w2_idle: got busy=%b ready=%b key=%b expected 0 0 00", busy2, ready2, key2); end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bv2 = 1'b1; bit2 = 1'b1;
    tick();
    bit2 = 1'b0;
    tick();
    checks++; if (ready2 !== 1'b0 || busy2 !== 1'b1) begin failures++; $display("[TB] FAIL w2_c3: got ready=%b busy=%b expected 0 1", ready2, busy2); end
    bit2 = 1'b1;
    tick();
    bv2 = 1'b0; bit2 = 1'b0;
    checks++; if (key2 !== 2'b01) begin failures++; $display("[TB] FAIL w2_key: got %b expected 01", key2); end
    checks++; if (ready2 !== 1'b1 || busy2 !== 1'b0 || error2 !== 1'b0) begin failures++; $display("[TB] FAIL w2_flags: got ready=%b busy=%b err=%b expected 1 0 0", ready2, busy2, error2); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_parity_error();
    test_gaps();
    test_back_to_back();
    test_reset_midload();
    test_clear();
    test_width2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
